instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder counterpart to the single-cycle controller's opcode/func decode.
- Accepts symbolic instruction requests (op class plus register, immediate and target fields) over a valid/ready handshake.
- Packs each request into a 32-bit instruction word using the exact opcode/func map the controller decodes.
- Buffers the words in a 2-entry FIFO and streams them into instruction memory at consecutive addresses. Used for program loading at boot and by the testbench.

Parameters:
- AW, 8, instruction-memory address width (word addressed).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin load session; honoured only in IDLE
- base_addr  input  AW  first imem write address; latched on start
- num_instr  input  AW  number of requests to accept; latched on start
- busy  output  1  high in LOAD and DRAIN
- done  output  1  one-cycle pulse in DONE
- err  output  1  sticky illegal-op flag; cleared by start
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready
- in_op  input  4  op class
- in_alu  input  3  ALU control for R/I ALU ops
- in_rs  input  5  rs field
- in_rt  input  5  rt field
- in_rd  input  5  rd field
- in_imm  input  16  immediate / branch offset
- in_target  input  26  jump target
- imem_we  output  1  write request
- imem_addr  output  AW  write address
- imem_wdata  output  32  instruction word
- imem_ready  input  1  write completes when imem_we && imem_ready
- wr_count  output  AW  words written this session

Behaviour:
- Word format: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt=0, [5:0] func; I-type [15:0]=imm; J-type [25:0]=target. Unused fields are 0.
- in_op map:
  - 0 R-ALU: opcode 000000, func={3'b000,in_alu}.
  - 1 I-ALU: opcode {3'b001,in_alu}.
  - 2 LW: 010000.
  - 3 SW: 010001.
  - 4 J: 011000.
  - 5 JR: 011001, rs only.
  - 6 JAL: 011010.
  - 7 BEQ: 011011.
  - 8 BNE: 011100.
  - 9-15 illegal.
- FSM IDLE→LOAD→DRAIN→DONE→IDLE:
  - IDLE: in_ready=0, imem_we=0. On start, latch base_addr and num_instr, clear acc_cnt, wr_count and err. Go to LOAD, or to DONE if num_instr==0.
  - LOAD: in_ready = !fifo_full && acc_cnt<num. Each accept increments acc_cnt and pushes the encoded word into the FIFO at the next edge (latency 1 clk to FIFO head when empty). When acc_cnt reaches num, go to DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty and no write is pending, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Write side (LOAD and DRAIN): imem_we = !fifo_empty. imem_wdata = FIFO head; imem_addr = base + wr_count. On imem_we && imem_ready, pop the FIFO and increment wr_count.
- imem_we, imem_addr and imem_wdata hold stable while imem_ready=0.
- FIFO behaviour:
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - When full, in_ready=0 even if a pop occurs that cycle (no pass-through).
- Address computation wraps modulo 2^AW (e.g. base=0xFE, N=4 writes to FE, FF, 00, 01).
- start outside IDLE is ignored.
- Reset mid-operation: at the next edge with rst_n=0, FIFO is flushed and state goes to IDLE. All outputs are 0 (busy, done, err, in_ready, imem_we, imem_addr, imem_wdata, wr_count); counters are 0.

Optional Feature:
- ENC_ILLEGAL_CHECK_EN
- Defined:
  - Illegal in_op (9-15) is still accepted and counts toward acc_cnt.
  - The word is not pushed; err is set (sticky until next start).
  - wr_count ends at N minus the number of illegal requests.
- Undefined:
  - Illegal in_op encodes 32'h0000_0000, which is pushed and written normally.
  - err is tied 0.

Test Plan:
- Reset: rst_n=0 for 2 clk mid-LOAD with FIFO holding 2 words -> all outputs 0, state IDLE, no imem_we afterwards.
- start, base=0x10, N=3 with R-ALU(alu=2, rs=1, rt=2, rd=3), I-ALU(alu=0, rs=4, rt=5, imm=0x0007), J(target=0x0000040), imem_ready=1 -> writes 0x00221802@0x10, 0x20850007@0x11, 0x60000040@0x12; then done pulse; wr_count=3.
- Backpressure: imem_ready=0 for 5 clk with N=4 -> in_ready drops after 2 accepts; imem_we/addr/wdata held stable; all 4 words written in order once ready rises.
- Wrap and branches: base=0xFF, N=2, BEQ(rs=1, rt=2, imm=0xFFFE), BNE(rs=3, rt=0, imm=0x0004) -> 0x6C22FFFE@0xFF, 0x70600004@0x00.
- N=0 start -> DONE next cycle, no imem_we, busy stays 0; start asserted while busy -> ignored.
- Illegal in_op=12 among 3 requests -> with ENC_ILLEGAL_CHECK_EN: err=1, wr_count=2. Without: word 0x00000000 written, wr_count=3, err=0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Packs symbolic instruction requests into 32-bit words and streams them into imem via a 2-entry FIFO.
// Optional macro ENC_ILLEGAL_CHECK_EN: drop illegal ops (in_op 9-15) and raise sticky err.
module instr_encoder_loader #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] num_instr,
   output logic          busy,
   output logic          done,
   output logic          err,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_op,
   input  logic [2:0]    in_alu,
   input  logic [4:0]    in_rs,
   input  logic [4:0]    in_rt,
   input  logic [4:0]    in_rd,
   input  logic [15:0]   in_imm,
   input  logic [25:0]   in_target,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   input  logic          imem_ready,
   output logic [AW-1:0] wr_count
);

   // Handshakes: a request transfers on a rising edge where in_valid && in_ready;
   // an imem write completes on a rising edge where imem_we && imem_ready, and
   // imem_we/imem_addr/imem_wdata do not change until that happens.

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] base_q, num_q, acc_cnt, wr_cnt;
   logic [31:0]   fifo_mem [2];
   logic          wr_ptr, rd_ptr;
   logic [1:0]    fifo_cnt;
   logic          fifo_full, fifo_empty;
   logic          accept, push, pop;
   logic [31:0]   enc_word;

   assign fifo_full  = (fifo_cnt == 2'd2);
   assign fifo_empty = (fifo_cnt == 2'd0);
   assign accept     = in_valid && in_ready;
   assign pop        = imem_we && imem_ready;

   always_comb begin
      enc_word = 32'h0000_0000;
      case (in_op)
         4'd0: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 3'b000, in_alu};
         4'd1: enc_word = {3'b001, in_alu, in_rs, in_rt, in_imm};
         4'd2: enc_word = {6'b010000, in_rs, in_rt, in_imm};
         4'd3: enc_word = {6'b010001, in_rs, in_rt, in_imm};
         4'd4: enc_word = {6'b011000, in_target};
         4'd5: enc_word = {6'b011001, in_rs, 21'd0};
         4'd6: enc_word = {6'b011010, in_target};
         4'd7: enc_word = {6'b011011, in_rs, in_rt, in_imm};
         4'd8: enc_word = {6'b011100, in_rs, in_rt, in_imm};
         default: enc_word = 32'h0000_0000;
      endcase
   end

`ifdef ENC_ILLEGAL_CHECK_EN
   logic illegal, err_q;
   assign illegal = (in_op > 4'd8);
   // Illegal requests still consume a slot of the session count but never reach imem.
   assign push    = accept && !illegal;
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (state == S_IDLE && start) begin
         err_q <= 1'b0;
      end else if (accept && illegal) begin
         err_q <= 1'b1;
      end
   end
`else
   assign push = accept;
   assign err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = (num_instr == '0) ? S_DONE : S_LOAD;
         S_LOAD:  if (acc_cnt == num_q) state_nxt = S_DRAIN;
         S_DRAIN: if (fifo_empty) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state == S_LOAD) || (state == S_DRAIN);
      done     = (state == S_DONE);
      in_ready = (state == S_LOAD) && !fifo_full && (acc_cnt < num_q);
      imem_we  = busy && !fifo_empty;
   end

   assign imem_addr  = base_q + wr_cnt;
   assign imem_wdata = fifo_mem[rd_ptr];
   assign wr_count   = wr_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_q      <= '0;
         num_q       <= '0;
         acc_cnt     <= '0;
         wr_cnt      <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_cnt    <= 2'd0;
         fifo_mem[0] <= 32'h0;
         fifo_mem[1] <= 32'h0;
      end else begin
         if (state == S_IDLE && start) begin
            base_q  <= base_addr;
            num_q   <= num_instr;
            acc_cnt <= '0;
            wr_cnt  <= '0;
         end
         if (accept) acc_cnt <= acc_cnt + 1'b1;
         if (push) begin
            fifo_mem[wr_ptr] <= enc_word;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
            wr_cnt <= wr_cnt + 1'b1;
         end
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encoding, backpressure, wrap, N=0, reset and illegal ops.
module tb_instr_encoder_loader;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] num_instr = '0;
   logic          busy, done, err, in_ready, imem_we;
   logic          in_valid = 1'b0;
   logic [3:0]    in_op = '0;
   logic [2:0]    in_alu = '0;
   logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0;
   logic [15:0]   in_imm = '0;
   logic [25:0]   in_target = '0;
   logic [AW-1:0] imem_addr, wr_count;
   logic [31:0]   imem_wdata;
   logic          imem_ready = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   logic [AW+31:0] exp_q[$];
   logic [AW+31:0] obs_q[$];

   instr_encoder_loader #(.AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .num_instr(num_instr), .busy(busy), .done(done), .err(err),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_alu(in_alu),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_target(in_target), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .imem_ready(imem_ready), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   // Records every completed imem write as {addr, data}.
   always @(posedge clk) begin
      if (rst_n && imem_we && imem_ready) obs_q.push_back({imem_addr, imem_wdata});
   end

   task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
      @(negedge clk);
      start = 1'b1; base_addr = b; num_instr = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] op, input logic [2:0] alu, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                       input logic [25:0] tgt);
      int cyc = 0;
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_alu = alu; in_rs = rs; in_rt = rt;
      in_rd = rd; in_imm = imm; in_target = tgt;
      while (!in_ready && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (!in_ready) begin
         miscompares++;
         $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, cyc);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
      end
   endtask

   task automatic wait_done();
      int cyc = 0;
      @(negedge clk);
      in_valid = 1'b0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL done_timeout: done=%0b, required 1", done);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL done_pulse: done=%0b busy=%0b, required 0 0", done, busy);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({busy, done, err, in_ready, imem_we} !== 5'b0 || imem_addr !== '0 ||
          imem_wdata !== 32'h0 || wr_count !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: busy=%0b done=%0b err=%0b in_ready=%0b we=%0b addr=%h wdata=%h wr_count=%h, required all 0",
                  busy, done, err, in_ready, imem_we, imem_addr, imem_wdata, wr_count);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid();
      imem_ready = 1'b0;
      do_start(8'h10, 8'd4);
      send(4'd2, 3'd0, 5'd1, 5'd2, 5'd0, 16'h0003, 26'd0);
      send(4'd3, 3'd0, 5'd1, 5'd2, 5'd0, 16'h0004, 26'd0);
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if (in_ready !== 1'b0 || imem_we !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_full: in_ready=%0b we=%0b, required 0 1", in_ready, imem_we);
      end
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, done, err, in_ready, imem_we} !== 5'b0 || imem_addr !== '0 ||
          imem_wdata !== 32'h0 || wr_count !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: busy=%0b done=%0b err=%0b in_ready=%0b we=%0b addr=%h wdata=%h wr_count=%h, required all 0",
                  busy, done, err, in_ready, imem_we, imem_addr, imem_wdata, wr_count);
      end
      rst_n = 1'b1;
      imem_ready = 1'b1;
      obs_q.delete();
      repeat (5) @(negedge clk);
      vectors++;
      if (obs_q.size() != 0 || imem_we !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_idle: writes=%0d we=%0b busy=%0b, required 0 0 0", obs_q.size(), imem_we, busy);
      end
   endtask

   task automatic test_basic();
      obs_q.delete(); exp_q.delete();
      imem_ready = 1'b1;
      exp_q.push_back({8'h10, 32'h0022_1802});
      exp_q.push_back({8'h11, 32'h2085_0007});
      exp_q.push_back({8'h12, 32'h6000_0040});
      do_start(8'h10, 8'd3);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_busy: busy=%0b, required 1", busy);
      end
      send(4'd0, 3'd2, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'd0);
      send(4'd1, 3'd0, 5'd4, 5'd5, 5'd9, 16'h0007, 26'd0);
      send(4'd4, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0000040);
      wait_done();
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL basic_count: writes=%0d, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL basic_write[%0d]: got %h, required %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
         end
      end
      vectors++;
      if (wr_count !== 8'd3) begin
         miscompares++;
         $display("FAIL basic_wr_count: got %0d, required 3", wr_count);
      end
   endtask

   task automatic test_backpressure();
      obs_q.delete(); exp_q.delete();
      imem_ready = 1'b0;
      exp_q.push_back({8'h20, 32'h4043_0010});
      exp_q.push_back({8'h21, 32'h4486_0020});
      exp_q.push_back({8'h22, 32'h67E0_0000});
      exp_q.push_back({8'h23, 32'h6BFF_FFFF});
      do_start(8'h20, 8'd4);
      send(4'd2, 3'd0, 5'd2, 5'd3, 5'd0, 16'h0010, 26'd0);
      send(4'd3, 3'd0, 5'd4, 5'd6, 5'd0, 16'h0020, 26'd0);
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_in_ready: got %0b, required 0", in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (imem_we !== 1'b1 || imem_addr !== 8'h20 || imem_wdata !== 32'h4043_0010 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: we=%0b addr=%h wdata=%h in_ready=%0b, required 1 20 40430010 0",
                     i, imem_we, imem_addr, imem_wdata, in_ready);
         end
         @(negedge clk);
      end
      imem_ready = 1'b1;
      send(4'd5, 3'd0, 5'd31, 5'd5, 5'd7, 16'h1234, 26'd0);
      send(4'd6, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h3FFFFFF);
      wait_done();
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL bp_count: writes=%0d, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL bp_write[%0d]: got %h, required %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
         end
      end
   endtask

   task automatic test_wrap_branches();
      obs_q.delete(); exp_q.delete();
      imem_ready = 1'b1;
      exp_q.push_back({8'hFF, 32'h6C22_FFFE});
      exp_q.push_back({8'h00, 32'h7060_0004});
      do_start(8'hFF, 8'd2);
      send(4'd7, 3'd0, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'd0);
      send(4'd8, 3'd0, 5'd3, 5'd0, 5'd0, 16'h0004, 26'd0);
      wait_done();
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL wrap_count: writes=%0d, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL wrap_write[%0d]: got %h, required %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
         end
      end
   endtask

   task automatic test_zero_and_ignore();
      obs_q.delete(); exp_q.delete();
      imem_ready = 1'b1;
      do_start(8'h55, 8'd0);
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || imem_we !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_done: done=%0b busy=%0b we=%0b, required 1 0 0", done, busy, imem_we);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || obs_q.size() != 0) begin
         miscompares++;
         $display("FAIL zero_after: done=%0b busy=%0b writes=%0d, required 0 0 0", done, busy, obs_q.size());
      end
      exp_q.push_back({8'h30, 32'h3C01_ABCD});
      do_start(8'h30, 8'd1);
      do_start(8'h80, 8'd5);
      send(4'd1, 3'd7, 5'd0, 5'd1, 5'd0, 16'hABCD, 26'd0);
      wait_done();
      vectors++;
      if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || wr_count !== 8'd1) begin
         miscompares++;
         $display("FAIL ignore_start: writes=%0d first=%h wr_count=%0d, required 1 %h 1",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, wr_count, exp_q[0]);
      end
   endtask

   task automatic test_illegal();
      logic exp_err;
      logic [AW-1:0] exp_wc;
      obs_q.delete(); exp_q.delete();
      imem_ready = 1'b1;
      exp_q.push_back({8'h40, 32'h4021_0001});
`ifdef ENC_ILLEGAL_CHECK_EN
      exp_q.push_back({8'h41, 32'h4400_0000});
      exp_err = 1'b1; exp_wc = 8'd2;
`else
      exp_q.push_back({8'h41, 32'h0000_0000});
      exp_q.push_back({8'h42, 32'h4400_0000});
      exp_err = 1'b0; exp_wc = 8'd3;
`endif
      do_start(8'h40, 8'd3);
      send(4'd2, 3'd0, 5'd1, 5'd1, 5'd0, 16'h0001, 26'd0);
      send(4'd12, 3'd5, 5'd9, 5'd9, 5'd9, 16'h5555, 26'h1555555);
      send(4'd3, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'd0);
      wait_done();
      vectors++;
      if (err !== exp_err || wr_count !== exp_wc) begin
         miscompares++;
         $display("FAIL illegal_status: err=%0b wr_count=%0d, required %0b %0d", err, wr_count, exp_err, exp_wc);
      end
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL illegal_count: writes=%0d, required %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL illegal_write[%0d]: got %h, required %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
         end
      end
      do_start(8'h00, 8'd0);
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL err_clear: err=%0b, required 0", err);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_basic();
      test_backpressure();
      test_wrap_branches();
      test_zero_and_ignore();
      test_illegal();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
